icache_ctrl_seq: RTL
====================

Name: icache_ctrl_seq

Overview:
- Sequencer between the cluster icache control registers and NB_BANKS instruction-cache banks.
- Accepts one cache-maintenance command at a time (bypass on/off, full flush, address-range flush) and drives the bank request lines.
- Collects per-bank acknowledges and expands a range flush into one selective flush per cache line.
- Also keeps saturating global hit/transaction/miss counters of width CNT_W.

Parameters:
- NB_BANKS, 4, number of cache banks acknowledging requests (>=1)
- ADDR_W, 32, flush address width
- LINE_BYTES, 16, cache line size in bytes (power of two, >=4)
- CNT_W, 32, performance counter width (>= clog2(NB_BANKS)+1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  sequencer idle, command accepted when valid&ready
- cmd_op_i  in  2  0=bypass on, 1=bypass off, 2=full flush, 3=range flush
- cmd_start_i  in  ADDR_W  range flush first byte address
- cmd_end_i  in  ADDR_W  range flush last byte address (inclusive)
- done_o  out  1  one-cycle pulse at command completion
- err_o  out  1  one-cycle pulse with done_o when range is empty (end<start)
- bypass_req_o  out  1  bypass request level to all banks
- bypass_ack_i  in  NB_BANKS  per-bank one-cycle ack
- flush_req_o  out  1  full flush request
- flush_ack_i  in  NB_BANKS  per-bank one-cycle ack
- sel_flush_req_o  out  1  selective flush request
- sel_flush_addr_o  out  ADDR_W  line-aligned address of current selective flush
- sel_flush_ack_i  in  NB_BANKS  per-bank one-cycle ack
- ev_trans_i  in  NB_BANKS  per-bank lookup strobe
- ev_hit_i  in  NB_BANKS  per-bank hit strobe (qualified by ev_trans_i)
- cnt_enable_i  in  1  counting enable
- cnt_clear_i  in  1  synchronous counter clear
- global_trans_cnt_o, global_hit_cnt_o, global_miss_cnt_o  out  CNT_W each  counters

Behaviour:
- Reset:
  - All outputs 0, state IDLE, ack mask 0, counters 0.
  - cmd_ready_o is 1 on the first cycle after reset release.
- States: IDLE, BYP_WAIT, FLUSH_WAIT, SEL_WAIT, DONE.
- IDLE: cmd_ready_o=1. On accept (cycle 0), from cycle 1:
  - op0: bypass_req_o<=1, go to BYP_WAIT.
  - op1: bypass_req_o<=0, go to BYP_WAIT.
  - op2: flush_req_o<=1, go to FLUSH_WAIT.
  - op3 with start<=end: cur<=start & ~(LINE_BYTES-1), lim<=end & ~(LINE_BYTES-1), sel_flush_req_o<=1, go to SEL_WAIT.
  - op3 with end<start: go to DONE with err flag set; no bank request issued.
- Ack collection, applies to all wait states:
  - Sticky mask |= relevant ack vector each cycle.
  - Acks arriving at bits already set are ignored.
  - Acks of non-active request types are ignored.
  - Mask is cleared when entering any wait state or advancing to the next line.
  - The cycle in which the mask OR the current acks equals all ones is the completion cycle.
- BYP_WAIT completion: go to DONE. bypass_req_o holds its new level permanently; it is not touched by other ops.
- FLUSH_WAIT completion: flush_req_o<=0, go to DONE.
- SEL_WAIT completion:
  - If cur==lim: sel_flush_req_o<=0, go to DONE.
  - Else: cur<=cur+LINE_BYTES, clear mask, stay in SEL_WAIT with req held high. The next line's address is visible the cycle after completion.
  - Range wraps at 2^ADDR_W are impossible because start<=end.
- sel_flush_addr_o = cur while in SEL_WAIT, else 0.
- DONE:
  - done_o=1 (and err_o=1 if flagged) for exactly one cycle, cmd_ready_o=0.
  - Next state IDLE.
  - Minimum command period is therefore 3 cycles with immediate acks.
- Commands presented while cmd_ready_o=0 are not accepted; cmd_valid_i may stay high.
- Counters:
  - When cnt_enable_i, each cycle add popcount(ev_trans_i) to trans, popcount(ev_trans_i & ev_hit_i) to hit, popcount(ev_trans_i & ~ev_hit_i) to miss.
  - Every counter saturates at 2^CNT_W-1; no wrap.
  - cnt_clear_i has priority over increment in the same cycle (result 0).
  - When cnt_enable_i=0, values hold.
- Reset mid-operation: all requests drop asynchronously, no done_o is produced, state returns to IDLE.

Test Plan:
- Full flush, NB_BANKS=4, acks from banks 0,1 in cycle 3, banks 2,3 in cycle 5 -> flush_req_o high cycles 1-5, done_o pulse in cycle 6, cmd_ready_o back in cycle 7.
- Range flush start=0x1004, end=0x1033, LINE_BYTES=16 -> sel_flush_addr_o sequence 0x1000, 0x1010, 0x1020, 0x1030, each held until all 4 acks collected; exactly one done_o.
- Range flush start=0x2000, end=0x1FFF -> no request asserted, done_o and err_o pulse together in cycle 1.
- Bypass on, with duplicate ack from bank 0 and stray flush_ack_i -> completes only when all bypass acks seen; bypass_req_o stays 1 through a subsequent full flush; bypass off drops it.
- Counters with CNT_W=4: ev_trans=4'hF, ev_hit=4'h5 for 4 cycles -> trans saturates at 15, hit=8, miss=8; cnt_clear_i together with events -> all 0.
- rst_ni asserted during SEL_WAIT on line 2 of 4 -> sel_flush_req_o=0 immediately, no done_o; a new command is accepted normally after reset release.

Source files
------------

// File: rtl/icache_ctrl_seq.sv
`default_nettype none
// ============================================================================
// icache_ctrl_seq : icache maintenance sequencer (bypass/flush/range flush)
//                   with saturating global hit/trans/miss counters.
// Revision: 1.0
// ============================================================================
module icache_ctrl_seq #(
  parameter int NB_BANKS   = 4,
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int CNT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [ADDR_W-1:0]   cmd_start_i,
  input  logic [ADDR_W-1:0]   cmd_end_i,
  output logic                done_o,
  output logic                err_o,
  output logic                bypass_req_o,
  input  logic [NB_BANKS-1:0] bypass_ack_i,
  output logic                flush_req_o,
  input  logic [NB_BANKS-1:0] flush_ack_i,
  output logic                sel_flush_req_o,
  output logic [ADDR_W-1:0]   sel_flush_addr_o,
  input  logic [NB_BANKS-1:0] sel_flush_ack_i,
  input  logic [NB_BANKS-1:0] ev_trans_i,
  input  logic [NB_BANKS-1:0] ev_hit_i,
  input  logic                cnt_enable_i,
  input  logic                cnt_clear_i,
  output logic [CNT_W-1:0]    global_trans_cnt_o,
  output logic [CNT_W-1:0]    global_hit_cnt_o,
  output logic [CNT_W-1:0]    global_miss_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BYP_WAIT   = 3'd1,
    S_FLUSH_WAIT = 3'd2,
    S_SEL_WAIT   = 3'd3,
    S_DONE       = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));
  localparam logic [ADDR_W-1:0] LINE_INC  = ADDR_W'(LINE_BYTES);

  state_e              state_q, state_d;
  logic                bypass_q, bypass_d;
  logic                flush_q, flush_d;
  logic                sel_q, sel_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   lim_q, lim_d;
  logic [NB_BANKS-1:0] mask_q, mask_d;
  logic [NB_BANKS-1:0] acks;
  logic                all_acked;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      bypass_q <= 1'b0;
      flush_q  <= 1'b0;
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
      cur_q    <= '0;
      lim_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      bypass_q <= bypass_d;
      flush_q  <= flush_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      cur_q    <= cur_d;
      lim_q    <= lim_d;
      mask_q   <= mask_d;
    end
  end

  // Only the ack vector matching the active wait state contributes to the mask.
  always_comb begin
    acks = '0;
    case (state_q)
      S_BYP_WAIT:   acks = bypass_ack_i;
      S_FLUSH_WAIT: acks = flush_ack_i;
      S_SEL_WAIT:   acks = sel_flush_ack_i;
      default:      acks = '0;
    endcase
  end

  assign all_acked = &(mask_q | acks);

  always_comb begin
    state_d  = state_q;
    bypass_d = bypass_q;
    flush_d  = flush_q;
    sel_d    = sel_q;
    err_d    = err_q;
    cur_d    = cur_q;
    lim_d    = lim_q;
    mask_d   = mask_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          mask_d = '0;
          err_d  = 1'b0;
          case (cmd_op_i)
            2'd0: begin
              bypass_d = 1'b1;
              state_d  = S_BYP_WAIT;
            end
            2'd1: begin
              bypass_d = 1'b0;
              state_d  = S_BYP_WAIT;
            end
            2'd2: begin
              flush_d = 1'b1;
              state_d = S_FLUSH_WAIT;
            end
            default: begin
              if (cmd_end_i < cmd_start_i) begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                cur_d   = cmd_start_i & LINE_MASK;
                lim_d   = cmd_end_i & LINE_MASK;
                sel_d   = 1'b1;
                state_d = S_SEL_WAIT;
              end
            end
          endcase
        end
      end
      S_BYP_WAIT: begin
        if (all_acked) begin
          mask_d  = '0;
          state_d = S_DONE;
        end else begin
          mask_d = mask_q | acks;
        end
      end
      S_FLUSH_WAIT: begin
        if (all_acked) begin
          mask_d  = '0;
          flush_d = 1'b0;
          state_d = S_DONE;
        end else begin
          mask_d = mask_q | acks;
        end
      end
      S_SEL_WAIT: begin
        if (all_acked) begin
          mask_d = '0;
          if (cur_q == lim_q) begin
            sel_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            cur_d = cur_q + LINE_INC;
          end
        end else begin
          mask_d = mask_q | acks;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o      = (state_q == S_IDLE) & rst_ni;
  assign done_o           = (state_q == S_DONE);
  assign err_o            = (state_q == S_DONE) & err_q;
  assign bypass_req_o     = bypass_q;
  assign flush_req_o      = flush_q;
  assign sel_flush_req_o  = sel_q;
  assign sel_flush_addr_o = (state_q == S_SEL_WAIT) ? cur_q : '0;

  // Performance counters
  logic [CNT_W:0]   pc_trans, pc_hit, pc_miss;
  logic [CNT_W-1:0] trans_q, hit_q, miss_q;

  always_comb begin
    pc_trans = '0;
    pc_hit   = '0;
    pc_miss  = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      pc_trans = pc_trans + (CNT_W+1)'(ev_trans_i[b]);
      pc_hit   = pc_hit   + (CNT_W+1)'(ev_trans_i[b] & ev_hit_i[b]);
      pc_miss  = pc_miss  + (CNT_W+1)'(ev_trans_i[b] & ~ev_hit_i[b]);
    end
  end

  // Increment never exceeds NB_BANKS, so one carry bit is enough to detect overflow.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + inc;
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trans_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else if (cnt_clear_i) begin
      trans_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else if (cnt_enable_i) begin
      trans_q <= sat_add(trans_q, pc_trans);
      hit_q   <= sat_add(hit_q, pc_hit);
      miss_q  <= sat_add(miss_q, pc_miss);
    end
  end

  assign global_trans_cnt_o = trans_q;
  assign global_hit_cnt_o   = hit_q;
  assign global_miss_cnt_o  = miss_q;

endmodule
`default_nettype wire
